prog_sequencer: RTL and testbench
=================================

# prog_sequencer

Program launch and branch-drive sequencer for `basic_proc`; it drives the program counter's control inputs. It turns the testbench Start/Done handshake into a PC reset hold, then a one-cycle absolute jump to the selected program's start address. While a program runs, it passes the core's branch requests through to the PC. It ends a run on the core's halt or on a cycle-budget timeout.

## Interface
Parameters:
- L, 10: PC / target width
- ADDR0, 0: start address, program 0
- ADDR1, 128: start address, program 1
- ADDR2, 256: start address, program 2
- CW, 16: cycle-counter width
- MAXCYC, 1000: run-cycle budget, 1 ≤ MAXCYC ≤ 2^CW−1

Ports:
- Clk  in  1  clock, all state changes on posedge
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  testbench request (level)
- Halt  in  1  core's decoded halt instruction
- BranchIn  in  1  core's branch request
- TargetIn  in  L  core's branch target
- ProgCtr  in  L  current PC value
- PcReset  out  1  to PC Reset; holds PC at 0
- BranchAbs  out  1  to PC BranchAbs
- Target  out  L  to PC Target
- Done  out  1  run finished (registered)
- TimeoutErr  out  1  run ended by budget, not Halt (registered)
- ProgIdx  out  2  selected program, 0..2 (registered)
- CycleCount  out  CW  cycles spent in RUN (registered)
- HaltPC  out  L  ProgCtr captured at halt (registered)

## Operation
FSM states: IDLE, ARMED, LAUNCH, RUN, DONE.
- Reset (async) forces state IDLE, ProgIdx=0, CycleCount=0, Done=0, TimeoutErr=0, HaltPC=0. Outputs then read PcReset=1, BranchAbs=0, Target=0.
- IDLE: PcReset=1. Start=1 → ARMED.
- ARMED: PcReset=1. Start=0 → LAUNCH.
- LAUNCH: lasts exactly 1 cycle.
  - PcReset=0, BranchAbs=1, Target=ADDR[ProgIdx].
  - CycleCount←0 at the exit edge, then → RUN.
- RUN: PcReset=0, BranchAbs=BranchIn, Target=TargetIn (combinational pass-through). Each edge, CycleCount←CycleCount+1. Priority, highest first:
  1. Start=1 → ARMED (abort); Done stays 0; ProgIdx unchanged.
  2. Halt=1 → DONE; HaltPC←ProgCtr.
  3. CycleCount==MAXCYC−1 → DONE; TimeoutErr←1.
  4. Otherwise stay in RUN.
- DONE: Done=1, PcReset=1, BranchAbs=0, Target=0.
  - BranchIn and Halt are ignored.
  - Start=1 → ARMED; Done←0, TimeoutErr←0, ProgIdx←(ProgIdx==2 ? 0 : ProgIdx+1).
- Outside RUN, BranchAbs and Target are 0 except during LAUNCH.
- Arithmetic: CycleCount is unsigned CW bits. It cannot exceed MAXCYC because the timeout fires first. ProgIdx value 3 is unreachable; if it occurs, decode it as ADDR0.

## Timing
- Launch latency: Start sampled 0 at edge k (state ARMED) → LAUNCH after edge k. ProgCtr==ADDR[ProgIdx] after edge k+1. First RUN cycle follows edge k+1.
- Pass-through branch in RUN: zero latency. PC takes TargetIn at the same edge BranchIn is sampled.
- CycleCount counts RUN cycles, including the cycle in which Halt is sampled. Halt in the first RUN cycle gives CycleCount=1.
- Timeout: with no Halt, Done=1 after exactly MAXCYC RUN cycles, with CycleCount=MAXCYC.
- Done and TimeoutErr rise on the edge leaving RUN. They fall on the edge leaving DONE.
- Start held high in DONE for several cycles: one ARMED entry and a single ProgIdx increment.
- Reset mid-operation: all outputs take their reset values immediately, without waiting for a clock edge.
- Reset released mid-cycle: first transition occurs at the next posedge.

## Test plan
1. Reset, then Start=1 for 2 cycles, then 0 → one LAUNCH cycle with BranchAbs=1, Target=0. Halt on the 5th RUN cycle with ProgCtr=0x004 → Done=1, CycleCount=5, HaltPC=0x004, TimeoutErr=0.
2. Repeat the handshake 3 more times → ProgIdx 1, 2, 0. LAUNCH Target=128, 256, 0 respectively.
3. RUN with BranchIn=1, TargetIn=0x123 → BranchAbs=1, Target=0x123 in the same cycle, and ProgCtr=0x123 after the edge. In DONE, BranchIn=1 → BranchAbs=0.
4. MAXCYC=8, no Halt → Done=1 after 8 RUN cycles, CycleCount=8, TimeoutErr=1. Next Start clears TimeoutErr.
5. Start=1 and Halt=1 in the same RUN cycle → state ARMED, Done=0, HaltPC unchanged, ProgIdx unchanged.
6. Assert Reset mid-RUN, between clock edges → PcReset=1, BranchAbs=0, Done=0, ProgIdx=0, CycleCount=0 before the next posedge.

Source files
------------

// File: rtl/prog_sequencer.sv
// Launch/branch sequencer for basic_proc: holds the PC in reset, jumps to the
// selected program's start address, passes core branches through, ends on halt or timeout.
module prog_sequencer #(
  parameter int unsigned L      = 10,
  parameter int unsigned ADDR0  = 0,
  parameter int unsigned ADDR1  = 128,
  parameter int unsigned ADDR2  = 256,
  parameter int unsigned CW     = 16,
  parameter int unsigned MAXCYC = 1000
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Halt,
  input  logic          BranchIn,
  input  logic [L-1:0]  TargetIn,
  input  logic [L-1:0]  ProgCtr,
  output logic          PcReset,
  output logic          BranchAbs,
  output logic [L-1:0]  Target,
  output logic          Done,
  output logic          TimeoutErr,
  output logic [1:0]    ProgIdx,
  output logic [CW-1:0] CycleCount,
  output logic [L-1:0]  HaltPC
);

  // state    | meaning
  // S_IDLE   | PC held at 0, waiting for Start to rise
  // S_ARMED  | PC held at 0, waiting for Start to fall
  // S_LAUNCH | one-cycle absolute jump to the program start address
  // S_RUN    | program executing, core branches passed to the PC
  // S_DONE   | run finished, results held until the next Start
  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_LAUNCH,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [CW-1:0] LAST_CYC = CW'(MAXCYC - 1);

  state_e        state_q, state_d;
  logic [1:0]    prog_idx_q, prog_idx_d;
  logic [CW-1:0] cycle_count_q, cycle_count_d;
  logic          done_q, done_d;
  logic          timeout_err_q, timeout_err_d;
  logic [L-1:0]  halt_pc_q, halt_pc_d;
  logic [L-1:0]  launch_addr;

  // Index 3 cannot be reached; it falls back to program 0.
  always_comb begin
    case (prog_idx_q)
      2'd1:    launch_addr = L'(ADDR1);
      2'd2:    launch_addr = L'(ADDR2);
      default: launch_addr = L'(ADDR0);
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      prog_idx_q    <= 2'd0;
      cycle_count_q <= '0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      halt_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      prog_idx_q    <= prog_idx_d;
      cycle_count_q <= cycle_count_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      halt_pc_q     <= halt_pc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    prog_idx_d    = prog_idx_q;
    cycle_count_d = cycle_count_q;
    done_d        = done_q;
    timeout_err_d = timeout_err_q;
    halt_pc_d     = halt_pc_q;
    PcReset       = 1'b1;
    BranchAbs     = 1'b0;
    Target        = '0;

    case (state_q)
      S_IDLE: begin
        if (Start) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (!Start) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        PcReset       = 1'b0;
        BranchAbs     = 1'b1;
        Target        = launch_addr;
        cycle_count_d = '0;
        state_d       = S_RUN;
      end
      S_RUN: begin
        PcReset       = 1'b0;
        BranchAbs     = BranchIn;
        Target        = TargetIn;
        cycle_count_d = cycle_count_q + CW'(1);
        // Abort beats halt, halt beats timeout.
        if (Start) begin
          state_d = S_ARMED;
        end else if (Halt) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          halt_pc_d = ProgCtr;
        end else if (cycle_count_q == LAST_CYC) begin
          state_d       = S_DONE;
          done_d        = 1'b1;
          timeout_err_d = 1'b1;
        end
      end
      S_DONE: begin
        if (Start) begin
          state_d       = S_ARMED;
          done_d        = 1'b0;
          timeout_err_d = 1'b0;
          prog_idx_d    = (prog_idx_q == 2'd2) ? 2'd0 : prog_idx_q + 2'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign Done       = done_q;
  assign TimeoutErr = timeout_err_q;
  assign ProgIdx    = prog_idx_q;
  assign CycleCount = cycle_count_q;
  assign HaltPC     = halt_pc_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: a simple PC model closes the loop, and a run-level
// reference model predicts PC flow, cycle counts, program rotation and results.
module tb_prog_sequencer;
  localparam int L      = 10;
  localparam int CW     = 16;
  localparam int MAXCYC = 8;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Start;
  logic          Halt;
  logic          BranchIn;
  logic [L-1:0]  TargetIn;
  logic [L-1:0]  ProgCtr;
  logic          PcReset;
  logic          BranchAbs;
  logic [L-1:0]  Target;
  logic          Done;
  logic          TimeoutErr;
  logic [1:0]    ProgIdx;
  logic [CW-1:0] CycleCount;
  logic [L-1:0]  HaltPC;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_idx  = 0;
  logic [L-1:0] exp_halt_pc = '0;

  prog_sequencer #(
    .L(L), .ADDR0(0), .ADDR1(128), .ADDR2(256), .CW(CW), .MAXCYC(MAXCYC)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .BranchIn(BranchIn),
    .TargetIn(TargetIn), .ProgCtr(ProgCtr), .PcReset(PcReset), .BranchAbs(BranchAbs),
    .Target(Target), .Done(Done), .TimeoutErr(TimeoutErr), .ProgIdx(ProgIdx),
    .CycleCount(CycleCount), .HaltPC(HaltPC)
  );

  always #5 Clk = ~Clk;

  // Program counter of the core being driven.
  always @(posedge Clk or posedge Reset) begin
    if (Reset)          ProgCtr <= '0;
    else if (PcReset)   ProgCtr <= '0;
    else if (BranchAbs) ProgCtr <= Target;
    else                ProgCtr <= ProgCtr + 1'b1;
  end

  function automatic logic [L-1:0] start_addr(input int idx);
    case (idx)
      1:       return L'(128);
      2:       return L'(256);
      default: return L'(0);
    endcase
  endfunction

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // From IDLE or DONE through ARMED and LAUNCH, ending in the first RUN cycle.
  task automatic launch(input int hold, input bit from_done);
    Start = 1'b1;
    repeat (hold) tick();
    if (from_done) exp_idx = (exp_idx + 1) % 3;
    n_checks++;
    if ({PcReset, BranchAbs, Done, TimeoutErr, ProgIdx} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'(exp_idx)}) begin
      n_fail++;
      $display("FAIL armed: got PcReset/BranchAbs/Done/TimeoutErr/ProgIdx=%b%b%b%b/%0d required 1000/%0d",
               PcReset, BranchAbs, Done, TimeoutErr, ProgIdx, exp_idx);
    end
    Start = 1'b0;
    tick();
    n_checks++;
    if ({PcReset, BranchAbs, Target} !== {1'b0, 1'b1, start_addr(exp_idx)}) begin
      n_fail++;
      $display("FAIL launch: got PcReset=%b BranchAbs=%b Target=%0d required 0 1 %0d",
               PcReset, BranchAbs, Target, start_addr(exp_idx));
    end
    tick();
    n_checks++;
    if (ProgCtr !== start_addr(exp_idx)) begin
      n_fail++;
      $display("FAIL launch_pc: got ProgCtr=%0d required %0d", ProgCtr, start_addr(exp_idx));
    end
  endtask

  // Runs from the first RUN cycle to DONE; halt_at 0 (or beyond budget) means no halt.
  task automatic run_prog(input int halt_at, input int br_pct);
    logic [L-1:0] exp_pc;
    int  cyc;
    bit  ended;
    bit  exp_to;
    exp_pc = start_addr(exp_idx);
    cyc    = 0;
    ended  = 1'b0;
    while (!ended) begin
      cyc++;
      n_checks++;
      if (ProgCtr !== exp_pc) begin
        n_fail++;
        $display("FAIL run_pc: cycle %0d got ProgCtr=%0d required %0d", cyc, ProgCtr, exp_pc);
      end
      BranchIn = ($urandom_range(0, 99) < br_pct);
      TargetIn = L'($urandom);
      Halt     = (cyc == halt_at);
      #1;
      n_checks++;
      if ({PcReset, BranchAbs, Target} !== {1'b0, BranchIn, TargetIn}) begin
        n_fail++;
        $display("FAIL passthru: got PcReset=%b BranchAbs=%b Target=%h required 0 %b %h",
                 PcReset, BranchAbs, Target, BranchIn, TargetIn);
      end
      if (Halt) exp_halt_pc = exp_pc;
      ended  = Halt || (cyc == MAXCYC);
      exp_pc = BranchIn ? TargetIn : L'(exp_pc + 1'b1);
      tick();
    end
    exp_to   = !(halt_at >= 1 && halt_at <= MAXCYC);
    Halt     = 1'b0;
    BranchIn = 1'b1;
    TargetIn = L'($urandom);
    #1;
    n_checks++;
    if ({Done, TimeoutErr, CycleCount, HaltPC, PcReset, BranchAbs, Target} !==
        {1'b1, exp_to, CW'(cyc), exp_halt_pc, 1'b1, 1'b0, {L{1'b0}}}) begin
      n_fail++;
      $display("FAIL done: got Done=%b TO=%b Cyc=%0d HaltPC=%h PcReset=%b BranchAbs=%b Target=%h required 1 %b %0d %h 1 0 000",
               Done, TimeoutErr, CycleCount, HaltPC, PcReset, BranchAbs, Target, exp_to, cyc, exp_halt_pc);
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1; Start = 1'b0; Halt = 1'b0; BranchIn = 1'b0; TargetIn = '0;
    #2;
    n_checks++;
    if ({PcReset, BranchAbs, Target, Done, TimeoutErr, ProgIdx, CycleCount, HaltPC} !==
        {1'b1, 1'b0, {L{1'b0}}, 1'b0, 1'b0, 2'd0, {CW{1'b0}}, {L{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset: got %b %b %h %b %b %0d %0d %h required 1 0 000 0 0 0 0 000",
               PcReset, BranchAbs, Target, Done, TimeoutErr, ProgIdx, CycleCount, HaltPC);
    end
    tick();
    Reset = 1'b0;
    tick();
    n_checks++;
    if ({PcReset, BranchAbs, Done} !== 3'b100) begin
      n_fail++;
      $display("FAIL idle: got PcReset/BranchAbs/Done=%b%b%b required 100", PcReset, BranchAbs, Done);
    end
    exp_idx = 0;
    exp_halt_pc = '0;
  endtask

  task automatic test_first_run;
    launch(2, 1'b0);
    run_prog(5, 0);
    n_checks++;
    if ({HaltPC, CycleCount} !== {10'h004, 16'd5}) begin
      n_fail++;
      $display("FAIL first_run: got HaltPC=%h CycleCount=%0d required 004 5", HaltPC, CycleCount);
    end
  endtask

  task automatic test_rotation;
    for (int i = 0; i < 3; i++) begin
      launch(2, 1'b1);
      n_checks++;
      if (ProgIdx !== 2'((i + 1) % 3)) begin
        n_fail++;
        $display("FAIL rotation: got ProgIdx=%0d required %0d", ProgIdx, (i + 1) % 3);
      end
      run_prog($urandom_range(1, MAXCYC), 30);
    end
  endtask

  task automatic test_branch;
    launch(2, 1'b1);
    BranchIn = 1'b1; TargetIn = 10'h123;
    #1;
    n_checks++;
    if ({BranchAbs, Target} !== {1'b1, 10'h123}) begin
      n_fail++;
      $display("FAIL branch_comb: got BranchAbs=%b Target=%h required 1 123", BranchAbs, Target);
    end
    tick();
    n_checks++;
    if (ProgCtr !== 10'h123) begin
      n_fail++;
      $display("FAIL branch_pc: got ProgCtr=%h required 123", ProgCtr);
    end
    BranchIn = 1'b0; Halt = 1'b1;
    tick();
    Halt = 1'b0; BranchIn = 1'b1; TargetIn = 10'h3ff;
    exp_halt_pc = 10'h123;
    #1;
    n_checks++;
    if ({Done, HaltPC, CycleCount, BranchAbs, Target} !== {1'b1, 10'h123, 16'd2, 1'b0, 10'h000}) begin
      n_fail++;
      $display("FAIL branch_done: got Done=%b HaltPC=%h Cyc=%0d BranchAbs=%b Target=%h required 1 123 2 0 000",
               Done, HaltPC, CycleCount, BranchAbs, Target);
    end
  endtask

  task automatic test_timeout;
    launch(2, 1'b1);
    run_prog(0, 20);
    launch(1, 1'b1);
    run_prog(MAXCYC, 0);
  endtask

  task automatic test_abort;
    launch(4, 1'b1);
    BranchIn = 1'b0;
    tick();
    tick();
    Start = 1'b1; Halt = 1'b1;
    tick();
    Start = 1'b0; Halt = 1'b0;
    n_checks++;
    if ({PcReset, Done, HaltPC, ProgIdx} !== {1'b1, 1'b0, exp_halt_pc, 2'(exp_idx)}) begin
      n_fail++;
      $display("FAIL abort: got PcReset=%b Done=%b HaltPC=%h ProgIdx=%0d required 1 0 %h %0d",
               PcReset, Done, HaltPC, ProgIdx, exp_halt_pc, exp_idx);
    end
    tick();
    n_checks++;
    if ({BranchAbs, Target} !== {1'b1, start_addr(exp_idx)}) begin
      n_fail++;
      $display("FAIL abort_relaunch: got BranchAbs=%b Target=%0d required 1 %0d",
               BranchAbs, Target, start_addr(exp_idx));
    end
    tick();
    run_prog(3, 50);
  endtask

  task automatic test_random;
    for (int i = 0; i < 10; i++) begin
      launch($urandom_range(1, 3), 1'b1);
      run_prog($urandom_range(0, MAXCYC + 3), 40);
    end
  endtask

  task automatic test_reset_mid_run;
    launch(1, 1'b1);
    if (exp_idx == 0) begin
      run_prog(2, 0);
      launch(1, 1'b1);
    end
    BranchIn = 1'b1; TargetIn = 10'h2aa;
    tick();
    tick();
    #2;
    Reset = 1'b1;
    #1;
    n_checks++;
    if ({PcReset, BranchAbs, Target, Done, TimeoutErr, ProgIdx, CycleCount} !==
        {1'b1, 1'b0, {L{1'b0}}, 1'b0, 1'b0, 2'd0, {CW{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_run: got %b %b %h %b %b %0d %0d required 1 0 000 0 0 0 0",
               PcReset, BranchAbs, Target, Done, TimeoutErr, ProgIdx, CycleCount);
    end
    tick();
    Reset = 1'b0;
    exp_idx = 0;
    exp_halt_pc = '0;
    launch(2, 1'b0);
    run_prog(0, 10);
    #2;
    Reset = 1'b1;
    #1;
    n_checks++;
    if ({Done, TimeoutErr, PcReset} !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_done: got Done/TO/PcReset=%b%b%b required 001", Done, TimeoutErr, PcReset);
    end
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_run();
    test_rotation();
    test_branch();
    test_timeout();
    test_abort();
    test_random();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
